// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: PC-source and error encodings,
// fetch FSM states and the word-size constant.
package pc_fetch_unit_pkg;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [1:0] PCSRC_BRANCH = 2'b00;
  localparam logic [1:0] PCSRC_SEQ    = 2'b01;
  localparam logic [1:0] PCSRC_JR     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_JR_ALIGN = 2'b10
  } fetch_err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the fetch stage, plus the Jal link
// value and the Jr alignment check.
module pc_fetch_unit_next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_offset,
  input  logic [31:0] jr_target,
  input  logic [25:0] jump_index,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        jr_misaligned
);

  assign pc_plus4 = pc + 32'(WORD_BYTES);

  // Branch offset is in words; all adds wrap modulo 2**32.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PCSRC_BRANCH: next_pc = pc_plus4 + (branch_offset << 2);
      PCSRC_SEQ:    next_pc = pc_plus4;
      PCSRC_JR:     next_pc = jr_target;
      default:      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    endcase
  end

  assign jr_misaligned = (pc_src == PCSRC_JR) && !is_word_aligned(jr_target);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the instruction until retire, and halts on timeout or bad Jr target.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 255,
  parameter int          TO_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        retire,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_offset,
  input  logic [31:0] jr_target,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halt,
  output logic [1:0]  err
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(IMEM_TIMEOUT);

  fetch_state_e    state_reg;
  fetch_err_e      err_reg;
  logic [31:0]     pc_reg;
  logic [31:0]     instr_reg;
  logic            instr_valid_reg;
  logic            imem_req_reg;
  logic            halt_reg;
  logic [TO_W-1:0] to_cnt_reg;

  logic [31:0]     next_pc;
  logic            jr_misaligned;
  logic            to_last;

  pc_fetch_unit_next_pc_calc u_next_pc (
    .pc            (pc_reg),
    .pc_src        (pc_src),
    .branch_offset (branch_offset),
    .jr_target     (jr_target),
    .jump_index    (jump_index),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4),
    .jr_misaligned (jr_misaligned)
  );

  // Request has been waiting IMEM_TIMEOUT-1 cycles; one more without ack expires it.
  assign to_last = ((to_cnt_reg + 1'b1) == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      err_reg         <= ERR_NONE;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'h0;
      instr_valid_reg <= 1'b0;
      imem_req_reg    <= 1'b0;
      halt_reg        <= 1'b0;
      to_cnt_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          imem_req_reg <= 1'b1;
          to_cnt_reg   <= '0;
          state_reg    <= ST_FETCH;
        end
        ST_FETCH: begin
          // Ack takes priority over an expiring timeout in the same cycle.
          if (imem_ack) begin
            instr_reg       <= imem_rdata;
            instr_valid_reg <= 1'b1;
            imem_req_reg    <= 1'b0;
            to_cnt_reg      <= '0;
            state_reg       <= ST_ISSUE;
          end else if (to_last) begin
            to_cnt_reg   <= to_cnt_reg + 1'b1;
            err_reg      <= ERR_TIMEOUT;
            halt_reg     <= 1'b1;
            imem_req_reg <= 1'b0;
            state_reg    <= ST_HALT;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        ST_ISSUE: begin
          if (retire) begin
            instr_valid_reg <= 1'b0;
            if (jr_misaligned) begin
              err_reg   <= ERR_JR_ALIGN;
              halt_reg  <= 1'b1;
              state_reg <= ST_HALT;
            end else begin
              pc_reg       <= next_pc;
              imem_req_reg <= 1'b1;
              to_cnt_reg   <= '0;
              state_reg    <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
        default: begin
          state_reg <= ST_HALT;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign pc          = pc_reg;
  assign halt        = halt_reg;
  assign err         = err_reg;

endmodule
